ccff_chain_loader: RTL and testbench

Configuration-chain loader that sits directly upstream of the logic-block configuration memories. It accepts bitstream words over a valid/ready stream and serialises them, one bit per enabled `prog_clk` cycle, onto the `ccff_head` of a scan chain of fixed length. An example is the 65-bit `{sram[0:63], mode}` chain of one frac_lut6 tile. It also drives the shift enable that gates the chain's clock. Optionally, it captures the old chain contents emerging on `ccff_tail` as readback words.

---
 rtl/ccff_chain_loader.sv | 134 +++++++++++++
 tb/tb_ccff_chain_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serialises bitstream words onto a config scan chain; define CCFF_READBACK_EN to capture ccff_tail as readback words
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 65,
  parameter int WORD_W = 8
) (
  input  logic              prog_clk,
  input  logic              pResetn,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done
`ifdef CCFF_READBACK_EN
  ,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
`endif
);
  localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int PAD = NWORDS * WORD_W - CHAIN_LEN;
  localparam int CW = $clog2(WORD_W + 1);
  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int NW = $clog2(NWORDS + 1);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
  state_t state_q, state_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic [CW-1:0] sh_cnt_q, sh_cnt_d;
  logic [BW-1:0] bits_left_q, bits_left_d;
  logic [NW-1:0] words_left_q, words_left_d;
  logic done_q, done_d;
  logic enter, shift, last, first, accept;
  assign enter = state_q != S_LOAD && start;
  assign shift = state_q == S_LOAD && sh_cnt_q != '0;
  assign last = shift && bits_left_q == BW'(1);
  assign first = words_left_q == NW'(NWORDS);
  assign s_ready = state_q == S_LOAD && words_left_q != '0 && (sh_cnt_q == '0 || (sh_cnt_q == CW'(1) && shift));
  assign accept = s_valid && s_ready;
  assign ccff_shift_en = shift;
  assign ccff_head = sh_q[WORD_W-1];
  assign busy = state_q == S_LOAD;
  assign done = done_q;
  // Next state: start launches a load from IDLE or DONE, the final chain capture ends it
  always_comb begin
    state_d = last ? S_DONE : enter ? S_LOAD : state_q;
    done_d = last ? 1'b1 : enter ? 1'b0 : done_q;
  end
  // Shift datapath: a word reloads the register as its last bit leaves, so streaming has no bubbles
  always_comb begin
    sh_d = sh_q;
    sh_cnt_d = sh_cnt_q;
    bits_left_d = bits_left_q;
    words_left_d = words_left_q;
    if (enter) begin
      sh_d = '0;
      sh_cnt_d = '0;
      bits_left_d = BW'(CHAIN_LEN);
      words_left_d = NW'(NWORDS);
    end else begin
      if (shift) begin
        sh_d = sh_q << 1;
        sh_cnt_d = sh_cnt_q - CW'(1);
        bits_left_d = bits_left_q - BW'(1);
      end
      if (accept) begin
        sh_d = first ? s_data << PAD : s_data;
        sh_cnt_d = first ? CW'(WORD_W - PAD) : CW'(WORD_W);
        words_left_d = words_left_q - NW'(1);
      end
    end
  end
  // State and datapath registers
  always_ff @(posedge prog_clk or negedge pResetn) begin
    if (!pResetn) begin
      state_q <= S_IDLE;
      sh_q <= '0;
      sh_cnt_q <= '0;
      bits_left_q <= '0;
      words_left_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      sh_cnt_q <= sh_cnt_d;
      bits_left_q <= bits_left_d;
      words_left_q <= words_left_d;
      done_q <= done_d;
    end
  end
`ifdef CCFF_READBACK_EN
  logic [WORD_W-1:0] rb_sh_q, rb_sh_d, rb_data_q, rb_data_d;
  logic [CW-1:0] rb_cnt_q, rb_cnt_d;
  logic rb_valid_q, rb_valid_d, emit;
  assign rb_data = rb_data_q;
  assign rb_valid = rb_valid_q;
  // Readback: collect old chain bits; a full word or the final partial word is left-aligned and strobed
  always_comb begin
    rb_sh_d = rb_sh_q;
    rb_cnt_d = rb_cnt_q;
    rb_data_d = rb_data_q;
    rb_valid_d = 1'b0;
    emit = shift && (rb_cnt_q == CW'(WORD_W - 1) || last);
    if (enter) begin
      rb_sh_d = '0;
      rb_cnt_d = '0;
    end else if (shift) begin
      rb_sh_d = {rb_sh_q[WORD_W-2:0], ccff_tail};
      rb_cnt_d = emit ? '0 : rb_cnt_q + CW'(1);
      rb_data_d = emit ? rb_sh_d << (CW'(WORD_W - 1) - rb_cnt_q) : rb_data_q;
      rb_valid_d = emit;
    end
  end
  // Readback registers
  always_ff @(posedge prog_clk or negedge pResetn) begin
    if (!pResetn) begin
      rb_sh_q <= '0;
      rb_cnt_q <= '0;
      rb_data_q <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_sh_q <= rb_sh_d;
      rb_cnt_q <= rb_cnt_d;
      rb_data_q <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: table-driven loads with a bit-level scoreboard against a chain model
module tb_ccff_chain_loader;
  localparam int L = 65, W = 8, NW = 9, P = 7;
  typedef struct {
    logic [W-1:0] wf, wm, wl;
    int stall_at, stall_len, mid_start;
    logic [L-1:0] pre;
    int exp_lat, exp_gaps;
  } vec_t;
  logic prog_clk = 1'b0, pResetn = 1'b1, start = 1'b0, s_valid = 1'b0;
  logic [W-1:0] s_data = '0;
  logic s_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done;
  logic start2 = 1'b0, s_valid2 = 1'b0;
  logic [3:0] s_data2 = '0;
  logic s_ready2, head2, sen2, tail2, busy2, done2;
`ifdef CCFF_READBACK_EN
  logic [W-1:0] rb_data;
  logic rb_valid;
  logic [3:0] rb_data2;
  logic rb_valid2;
`endif
  logic [L-1:0] chain = '0, pre_val = '0;
  logic preload = 1'b0;
  logic [2:0] chain2 = 3'b011;
  logic exp_q[$];
  logic [W-1:0] rb_q[$];
  int n_vec = 0, n_err = 0, cyc = 0, nshift = 0, ngap = 0, nacc = 0, done_cyc = -1;
  logic done_prev = 1'b0;
  vec_t vt[4];

  ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W)) dut (
    .prog_clk(prog_clk), .pResetn(pResetn), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
    .busy(busy), .done(done)
`ifdef CCFF_READBACK_EN
    , .rb_data(rb_data), .rb_valid(rb_valid)
`endif
  );
  ccff_chain_loader #(.CHAIN_LEN(3), .WORD_W(4)) dut2 (
    .prog_clk(prog_clk), .pResetn(pResetn), .start(start2), .s_data(s_data2), .s_valid(s_valid2),
    .s_ready(s_ready2), .ccff_head(head2), .ccff_shift_en(sen2), .ccff_tail(tail2),
    .busy(busy2), .done(done2)
`ifdef CCFF_READBACK_EN
    , .rb_data(rb_data2), .rb_valid(rb_valid2)
`endif
  );

  always #5 prog_clk = ~prog_clk;
  always @(posedge prog_clk) cyc <= cyc + 1;
  assign ccff_tail = chain[L-1];
  assign tail2 = chain2[2];
  always @(posedge prog_clk)
    if (preload) chain <= pre_val;
    else if (ccff_shift_en) chain <= {chain[L-2:0], ccff_head};
  always @(posedge prog_clk) if (sen2) chain2 <= {chain2[1:0], head2};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_rb(input logic [L-1:0] c);
    rb_q.delete();
    for (int k = 0; k < NW - 1; k++) rb_q.push_back(c[L-1-W*k -: W]);
    rb_q.push_back({c[0], {(W-1){1'b0}}});
  endtask

  always @(negedge prog_clk) if (pResetn) begin
    if (ccff_shift_en) begin
      nshift++;
      chk("head_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("head_bit", ccff_head, exp_q.pop_front());
    end else if (busy) ngap++;
    if (s_valid && s_ready) begin
      for (int i = (nacc == 0 ? W - P : W) - 1; i >= 0; i--) exp_q.push_back(s_data[i]);
      nacc++;
    end
    if (done && !done_prev) done_cyc = cyc;
    done_prev = done;
`ifdef CCFF_READBACK_EN
    if (rb_valid) begin
      chk("rb_expected", rb_q.size() != 0, 1);
      if (rb_q.size() != 0) begin
        chk("rb_word", rb_data, rb_q.pop_front());
        chk("rb_done_align", done, rb_q.size() == 0);
      end
    end
`endif
  end

  task automatic run_load(input vec_t v);
    logic [W-1:0] w[NW];
    logic [L-1:0] exp_chain;
    logic ok;
    int t0;
    exp_chain = '0;
    for (int i = 0; i < NW; i++) begin
      w[i] = (i == 0) ? v.wf : (i == NW - 1) ? v.wl : v.wm;
      for (int b = (i == 0 ? W - P : W) - 1; b >= 0; b--) exp_chain = {exp_chain[L-2:0], w[i][b]};
    end
    pre_val = v.pre;
    preload = 1'b1;
    @(posedge prog_clk);
    #1 preload = 1'b0;
    push_rb(v.pre);
    exp_q.delete();
    nshift = 0; ngap = 0; nacc = 0; done_cyc = -1;
    start = 1'b1;
    @(posedge prog_clk);
    #1 start = 1'b0;
    t0 = cyc;
    chk("done_cleared", done, 0);
    chk("busy_on", busy, 1);
    fork
      begin
        for (int i = 0; i <= NW; i++) begin
          if (i == v.stall_at) begin
            s_valid = 1'b0;
            ok = 1'b0;
            for (int c = 0; c < 40 && !ok; c++) begin
              @(negedge prog_clk);
              ok = s_ready;
            end
            repeat (v.stall_len) @(posedge prog_clk);
            #1;
          end
          s_valid = 1'b1;
          s_data = (i < NW) ? w[i] : 8'h5A;
          ok = 1'b0;
          for (int c = 0; c < 40 && !ok && !done; c++) begin
            @(negedge prog_clk);
            ok = s_ready;
            @(posedge prog_clk);
            #1;
          end
          if (i < NW) chk("word_accepted", ok, 1);
          else begin
            chk("word10_refused", ok, 0);
            chk("done_reached", done, 1);
          end
        end
        s_valid = 1'b0;
      end
      begin
        if (v.mid_start > 0) begin
          repeat (v.mid_start) @(posedge prog_clk);
          #1 start = 1'b1;
          @(posedge prog_clk);
          #1 start = 1'b0;
        end
      end
    join
    @(negedge prog_clk);
    #1;
    chk("latency", done_cyc - t0, v.exp_lat);
    chk("shifts", nshift, L);
    chk("gaps", ngap, v.exp_gaps);
    chk("accepts", nacc, NW);
    chk("chain", chain, exp_chain);
    chk("busy_off", busy, 0);
    chk("head_q_empty", exp_q.size(), 0);
`ifdef CCFF_READBACK_EN
    chk("rb_q_empty", rb_q.size(), 0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] bits2;
    int n2, acc2, t0;
`ifdef CCFF_READBACK_EN
    int rbn2;
    logic [3:0] rbd2;
    logic rbdone2;
    rbn2 = 0; rbd2 = '0; rbdone2 = 1'b0;
`endif
    vt[0] = '{8'hFF, 8'hA5, 8'h01, -1, 0, 0, 65'h1_0123_4567_89AB_CDEF, 66, 1};
    vt[1] = '{8'hFF, 8'hA5, 8'h01, 3, 5, 0, 65'h0_FEDC_BA98_7654_3210, 71, 6};
    vt[2] = '{8'h00, 8'h3C, 8'h80, -1, 0, 20, 65'h1_AAAA_5555_F0F0_0F0F, 66, 1};
    vt[3] = '{8'h01, 8'hF0, 8'hFE, 6, 2, 0, 65'h0_1357_9BDF_2468_ACE0, 68, 3};
    #3 pResetn = 1'b0;
    #1;
    chk("rst_ready", s_ready, 0);
    chk("rst_head", ccff_head, 0);
    chk("rst_shift_en", ccff_shift_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
`ifdef CCFF_READBACK_EN
    chk("rst_rb", {rb_valid, rb_data}, 0);
`endif
    @(negedge prog_clk);
    #2 pResetn = 1'b1;
    for (int i = 0; i < 4; i++) run_load(vt[i]);
    exp_q.delete();
    push_rb(chain);
    nshift = 0; nacc = 0;
    start = 1'b1;
    @(posedge prog_clk);
    #1 start = 1'b0;
    s_valid = 1'b1;
    s_data = 8'hA5;
    for (int c = 0; c < 100 && nshift < 30; c++) begin
      @(negedge prog_clk);
      #2;
    end
    chk("reached_30_shifts", nshift, 30);
    pResetn = 1'b0;
    #1;
    chk("arst_ready", s_ready, 0);
    chk("arst_head", ccff_head, 0);
    chk("arst_shift_en", ccff_shift_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
`ifdef CCFF_READBACK_EN
    chk("arst_rb", {rb_valid, rb_data}, 0);
`endif
    repeat (3) @(negedge prog_clk);
    #2 pResetn = 1'b1;
    exp_q.delete();
    rb_q.delete();
    for (int c = 0; c < 5; c++) begin
      @(negedge prog_clk);
      chk("idle_busy", busy, 0);
      chk("stray_ready", s_ready, 0);
    end
    s_valid = 1'b0;
    run_load(vt[0]);
    start2 = 1'b1;
    @(posedge prog_clk);
    #1 start2 = 1'b0;
    t0 = cyc;
    s_valid2 = 1'b1;
    s_data2 = 4'hD;
    bits2 = '0; n2 = 0; acc2 = 0;
    for (int c = 0; c < 20 && !done2; c++) begin
      @(negedge prog_clk);
      if (sen2) begin
        bits2 = {bits2[1:0], head2};
        n2++;
      end
      if (s_valid2 && s_ready2) acc2++;
`ifdef CCFF_READBACK_EN
      if (rb_valid2) begin
        rbn2++;
        rbd2 = rb_data2;
        rbdone2 = done2;
      end
`endif
    end
    s_valid2 = 1'b0;
    chk("small_bits", bits2, 3'b101);
    chk("small_shifts", n2, 3);
    chk("small_latency", cyc - t0, 4);
    chk("small_accepts", acc2, 1);
    chk("small_chain", chain2, 3'b101);
`ifdef CCFF_READBACK_EN
    chk("small_rb_count", rbn2, 1);
    chk("small_rb_data", rbd2, 4'h6);
    chk("small_rb_with_done", rbdone2, 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
